// File: rtl/ge_prog_sequencer.sv
// ge_prog_sequencer: sequenced executor for evolved register-op programs.
// A 4-entry scratch file r0..r3 is seeded from a0/a1/b0/b1. A loaded program
// runs at one instruction per cycle. The result is then offered on y3..y0
// through a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   prog_we/addr/data   instruction write port {op[7:5], dst[4:3], src[2:0]}, IDLE only
//   prog_len            number of instructions to run, sampled at start
//   start               run request, IDLE only
//   a0, a1, b0, b1      operands, sampled at start
//   busy                high while executing or holding a result
//   out_valid/out_ready result handshake
//   y3..y0              scratch registers r3..r0
module ge_prog_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [7:0]       prog_data,
  input  logic [AW:0]      prog_len,
  input  logic             start,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y0
);

  localparam int unsigned LW = AW + 1;

  localparam logic [2:0] OP_NOT = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    pc_q, pc_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] r_q    [4];
  logic [WIDTH-1:0] r_d    [4];
  logic [WIDTH-1:0] opnd_q [4];
  logic [WIDTH-1:0] opnd_d [4];
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  logic [7:0]       mem [DEPTH];
  logic [7:0]       instr;
  logic [2:0]       op;
  logic [1:0]       dst;
  logic [2:0]       src;
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] dst_val;
  logic [WIDTH-1:0] alu_res;
  logic [LW-1:0]    len_sat;

  // Program store: writable only while idle, deliberately not reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign instr   = mem[pc_q[AW-1:0]];
  assign op      = instr[7:5];
  assign dst     = instr[4:3];
  assign src     = instr[2:0];
  assign len_sat = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;

  // Single-op ALU; all reads see pre-update register values.
  always_comb begin
    src_val = src[2] ? opnd_q[src[1:0]] : r_q[src[1:0]];
    dst_val = r_q[dst];
    alu_res = dst_val;
    case (op)
      OP_NOT:  alu_res = WIDTH'(src_val == '0);
      OP_OR:   alu_res = dst_val | src_val;
      OP_AND:  alu_res = dst_val & src_val;
      OP_XOR:  alu_res = dst_val ^ src_val;
      OP_MOV:  alu_res = src_val;
      default: alu_res = dst_val;
    endcase
  end

  // Next-state and register update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    r_d         = r_q;
    opnd_d      = opnd_q;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d  = '{a0, a1, b0, b1};
          r_d     = '{a0, a1, b0, b1};
          len_d   = len_sat;
          pc_d    = '0;
          state_d = (len_sat != '0) ? EXEC : DONE;
        end
      end
      EXEC: begin
        r_d[dst] = alu_res;
        pc_d     = pc_q + LW'(1);
        if (pc_q == len_q - LW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Valid rises one cycle after entering DONE and drops on acceptance.
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_q[i]    <= '0;
        opnd_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      opnd_q      <= opnd_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign y0        = r_q[0];
  assign y1        = r_q[1];
  assign y2        = r_q[2];
  assign y3        = r_q[3];

endmodule

// File: tb/tb_ge_prog_sequencer.sv
// tb_ge_prog_sequencer: directed, table-driven bench for ge_prog_sequencer.
// Table vectors cover single runs. Hand-written sequences cover backpressure,
// reset mid-run, a write in the same cycle as start, and length saturation.
module tb_ge_prog_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [7:0]       prog_data;
  logic [AW:0]      prog_len;
  logic             start;
  logic [WIDTH-1:0] a0, a1, b0, b1;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y3, y2, y1, y0;

  int n_checks = 0;
  int n_fail   = 0;

  ge_prog_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .start(start),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] prog;   // byte i at [8*i +: 8]
    logic [1:0]  nprog;
    logic [6:0]  len;
    logic [15:0] a0, a1, b0, b1;
    logic [15:0] y0, y1, y2, y3;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [23:0] prog, input logic [1:0] nprog,
                              input logic [6:0] len,
                              input logic [15:0] va0, va1, vb0, vb1,
                              input logic [15:0] e0, e1, e2, e3,
                              input logic [7:0] lat);
    vec_t v;
    v.prog = prog; v.nprog = nprog; v.len = len;
    v.a0 = va0; v.a1 = va1; v.b0 = vb0; v.b1 = vb1;
    v.y0 = e0; v.y1 = e1; v.y2 = e2; v.y3 = e3;
    v.lat = lat;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_y(input string tag, input logic [15:0] e0, e1, e2, e3);
    check($sformatf("%s.y0", tag), 32'(y0), 32'(e0));
    check($sformatf("%s.y1", tag), 32'(y1), 32'(e1));
    check($sformatf("%s.y2", tag), 32'(y2), 32'(e2));
    check($sformatf("%s.y3", tag), 32'(y3), 32'(e3));
  endtask

  task automatic write_instr(input logic [AW-1:0] addr, input logic [7:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  // Start a run, then scramble the sampled inputs to show they are not re-read.
  task automatic start_run(input logic [6:0] len, input logic [15:0] va0, va1, vb0, vb1);
    prog_len = len;
    a0 = va0; a1 = va1; b0 = vb0; b1 = vb1;
    start = 1'b1;
    tick();
    start    = 1'b0;
    a0 = 16'hDEAD; a1 = 16'hBEEF; b0 = 16'hCAFE; b1 = 16'hF00D;
    prog_len = 7'd0;
  endtask

  // Cycles from the start edge until out_valid, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 200);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("%s.valid_drop", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s.busy_drop", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    vec_t v;

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; out_ready = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;

    //                prog        n  len a0       a1       b0       b1       y0       y1       y2       y3     lat
    vecs[0] = mk(24'h000000, 0, 0, 16'h00F0, 16'h0F00, 16'h1234, 16'h0000,
                 16'h00F0, 16'h0F00, 16'h1234, 16'h0000, 1);
    vecs[1] = mk(24'h003417, 2, 2, 16'h00F0, 16'h0F00, 16'h1234, 16'h0000,
                 16'h00F0, 16'h0F00, 16'h00F1, 16'h0000, 3);
    vecs[2] = mk(24'h003417, 2, 2, 16'h00F0, 16'h0F00, 16'h1234, 16'h0005,
                 16'h00F0, 16'h0F00, 16'h00F0, 16'h0005, 3);
    vecs[3] = mk(24'hE02F50, 3, 3, 16'h00FF, 16'h1200, 16'h0F0F, 16'h8001,
                 16'h00FF, 16'h9201, 16'h000F, 16'h8001, 4);
    vecs[4] = mk(24'h887B65, 3, 1, 16'h00F0, 16'h0F00, 16'h1234, 16'h0BAD,
                 16'h0FF0, 16'h0F00, 16'h1234, 16'h0BAD, 2);
    vecs[5] = mk(24'h887B65, 3, 3, 16'h00F0, 16'h0F00, 16'h1234, 16'hBEEF,
                 16'h0FF0, 16'h0FF0, 16'h1234, 16'h0000, 4);

    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.valid", 32'(out_valid), 32'd0);
    check_y("reset", 16'h0, 16'h0, 16'h0, 16'h0);

    // Table-driven single runs.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      for (int b = 0; b < int'(v.nprog); b++) begin
        write_instr(AW'(b), v.prog[8*b +: 8]);
      end
      start_run(v.len, v.a0, v.a1, v.b0, v.b1);
      wait_valid(cyc);
      check($sformatf("vec%0d.latency", i), 32'(cyc), 32'(v.lat));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'd1);
      check_y($sformatf("vec%0d", i), v.y0, v.y1, v.y2, v.y3);
      accept($sformatf("vec%0d", i));
    end

    // Backpressure: result holds, start/prog_we/operand changes are ignored.
    start_run(7'd3, 16'h00F0, 16'h0F00, 16'h1234, 16'h0000);
    wait_valid(cyc);
    check("bp.latency", 32'(cyc), 32'd4);
    for (int c = 0; c < 5; c++) begin
      a0 = 16'hFFFF; start = 1'b1; prog_len = 7'd0;
      prog_we = 1'b1; prog_addr = '0; prog_data = 8'hE0;
      tick();
      check($sformatf("bp%0d.valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d.busy", c), 32'(busy), 32'd1);
      check_y($sformatf("bp%0d", c), 16'h0FF0, 16'h0FF0, 16'h1234, 16'h0000);
    end
    start = 1'b0; prog_we = 1'b0;
    accept("bp");
    check_y("bp.retain", 16'h0FF0, 16'h0FF0, 16'h1234, 16'h0000);
    start_run(7'd3, 16'h00F0, 16'h0F00, 16'h1234, 16'h0000);
    wait_valid(cyc);
    check("bp_rerun.latency", 32'(cyc), 32'd4);
    check_y("bp_rerun", 16'h0FF0, 16'h0FF0, 16'h1234, 16'h0000);
    accept("bp_rerun");

    // Reset in the second EXEC cycle aborts the run immediately.
    start_run(7'd3, 16'h00F0, 16'h0F00, 16'h1234, 16'h0000);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.valid", 32'(out_valid), 32'd0);
    check_y("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    #12 rst_n = 1'b1;
    tick();
    check("rst_idle.valid", 32'(out_valid), 32'd0);
    start_run(7'd3, 16'h00F0, 16'h0F00, 16'h1234, 16'h0000);
    wait_valid(cyc);
    check("rst_rerun.latency", 32'(cyc), 32'd4);
    check_y("rst_rerun", 16'h0FF0, 16'h0FF0, 16'h1234, 16'h0000);
    accept("rst_rerun");

    // Write and start in one cycle: the new instruction (MOV r0,b1) runs.
    prog_we = 1'b1; prog_addr = '0; prog_data = 8'h87;
    prog_len = 7'd1; a0 = 16'h0001; a1 = 16'h0002; b0 = 16'h0003; b1 = 16'h0ABC;
    start = 1'b1;
    tick();
    start = 1'b0; prog_we = 1'b0; b1 = 16'h5555;
    wait_valid(cyc);
    check("wr_start.latency", 32'(cyc), 32'd2);
    check_y("wr_start", 16'h0ABC, 16'h0002, 16'h0003, 16'h0ABC);
    accept("wr_start");

    // prog_len above DEPTH saturates; all-NOP program leaves the seeds.
    for (int a = 0; a < int'(DEPTH); a++) begin
      write_instr(AW'(a), 8'hE0);
    end
    start_run(7'(DEPTH + 1), 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0);
    wait_valid(cyc);
    check("sat.latency", 32'(cyc), 32'(DEPTH + 1));
    check_y("sat", 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0);
    accept("sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ge_prog_sequencer.md
Name: ge_prog_sequencer

Overview:
- Sequenced executor for evolved register-op programs of the sloth_pid individuals.
- Holds a 4-register scratch file r0..r3 seeded from operands a0, a1, b0, b1.
- Executes a loaded program of one-op-per-cycle instructions (NOT / OR= / AND= / XOR= / MOV) and presents r3..r0 as y3..y0 through a valid/ready handshake.
- Lets one datapath evaluate any individual by reprogramming instead of resynthesis.

Parameters:
- WIDTH, 16, operand/register width.
- DEPTH, 64, instruction memory entries (power of two).
- AW, $clog2(DEPTH), program address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  instruction write strobe; honoured in IDLE only.
- prog_addr  in  AW  instruction write address.
- prog_data  in  8  instruction word {op[7:5], dst[4:3], src[2:0]}.
- prog_len  in  AW+1  instructions to execute; sampled at start.
- start  in  1  run request; honoured in IDLE only.
- a0, a1, b0, b1  in  WIDTH  operands; sampled at start.
- busy  out  1  high in EXEC and DONE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y3, y2, y1, y0  out  WIDTH  driven directly from r3, r2, r1, r0.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=0, r0..r3=0, operand latches=0, busy=0, out_valid=0.
  - Instruction memory is not reset and keeps its contents across rst_n.
- States IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - prog_we writes mem[prog_addr]=prog_data.
  - On start: latch the operands; load r0=a0, r1=a1, r2=b0, r3=b1; latch len=min(prog_len,DEPTH); pc=0.
  - Next state is EXEC if len>0, else DONE.
  - start and prog_we in the same cycle: the write lands first, so the new instruction is visible to the run.
- EXEC: each cycle executes mem[pc] and increments pc. After the instruction with pc==len-1, next state is DONE.
- Instruction semantics:
  - Source s: 0..3 = current r0..r3; 4..7 = latched a0, a1, b0, b1.
  - op 0 NOT: rd = (s==0) ? 1 : 0. Logical not, zero-extended to WIDTH, not bitwise.
  - op 1: rd |= s. op 2: rd &= s. op 3: rd ^= s. op 4 MOV: rd = s.
  - op 5..7: NOP.
  - Self-source ops (e.g. r3 ^= r3) read the pre-update value.
- Latency: start sampled at edge k; out_valid rises at edge k+len+1. For len=0 it rises at edge k+1.
- DONE:
  - out_valid=1; y outputs and registers hold.
  - out_valid&&out_ready -> IDLE, out_valid=0 on the same edge. r0..r3 retain their values.
- Ignored inputs:
  - start and prog_we are ignored in EXEC/DONE.
  - a*/b*/prog_len changes after start have no effect on the current run.
- prog_len>DEPTH saturates to DEPTH; pc never wraps within a run.
- Reset mid-EXEC or mid-DONE aborts the run: outputs return to reset values, no partial valid.
- out_ready is ignored when out_valid=0.

Test Plan:
1. Empty program: prog_len=0, a0=16'h00F0, a1=16'h0F00, b0=16'h1234, b1=16'h0000, start -> out_valid at start+1 with y0=00F0, y1=0F00, y2=1234, y3=0000; busy=1 until the out_ready cycle.
2. Logical NOT: program [NOT r2,b1 (0x17); OR r2,a0 (0x34)], same operands -> y2=16'h00F1. Rerun with b1=16'h0005 -> y2=16'h00F0.
3. Self-XOR and MOV: [XOR r0,a1 (0x65); XOR r3,r3 (0x7B); MOV r1,r0 (0x88)] -> y0=0FF0, y1=0FF0, y3=0000; out_valid exactly 4 cycles after start.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE; change a0 and pulse start/prog_we -> outputs stable, no write lands; out_ready=1 -> IDLE next edge.
5. Saturation/NOP: prog_len=DEPTH+1 with all NOPs (0xE0) -> out_valid after exactly DEPTH+1 cycles, y equals the seeded operands.
6. Reset mid-run: assert rst_n=0 at EXEC cycle 2 -> busy=0, out_valid=0, y=0 immediately. After release, rerun of test 3 gives identical results (memory retained).
